htpa_window_scanner: RTL and testbench

Parametrised coordinate generator that raster-scans a rectangular sub-window of the HTPA thermopile frame held in pixel RAM. It emits one (x, y) pair per accepted cycle, with per-axis decimation steps, downstream back-pressure, a linear pixel index, and last/done markers. It sits between the frame-control logic that issues START and the RAM read port / pixel pipeline that consumes coordinates.

---
 rtl/htpa_window_scanner.sv | 180 ++++++++++++++++++
 tb/tb_htpa_window_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/htpa_window_scanner.sv
// Raster coordinate generator over a sub-window of the HTPA pixel RAM.
// Optional serpentine row ordering is enabled by defining SCAN_SERPENTINE_EN.
module htpa_window_scanner #(
  parameter int XW = 7,
  parameter int YW = 6,
  parameter int SW = 3
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   START,
  input  logic [2*XW+2*YW-1:0]   window,
  input  logic [SW-1:0]          x_step,
  input  logic [SW-1:0]          y_step,
  input  logic                   ready,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic [XW+YW-1:0]       idx,
  output logic                   valid,
  output logic                   last,
  output logic                   done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_n;
  logic [XW-1:0]     x_q, x_n, xs_q, xs_n, xe_q, xe_n;
  logic [YW-1:0]     y_q, y_n, ys_q, ys_n, ye_q, ye_n;
  logic [SW-1:0]     xst_q, xst_n, yst_q, yst_n;
  logic [XW+YW-1:0]  idx_q, idx_n;
  logic              done_q, done_n;

  logic [XW-1:0]     w_xs, w_xe;
  logic [YW-1:0]     w_ys, w_ye;
  logic [XW:0]       nx;
  logic [YW:0]       ny;
  logic              x_fits, col_end, row_more, hs;
  logic [XW-1:0]     row_next;

`ifdef SCAN_SERPENTINE_EN
  logic              dir_q, dir_n;
  logic [XW-1:0]     xfar_q, xfar_n;
  logic [XW:0]       bx;
  logic              bx_fits;
`endif

  assign w_xs = window[2*XW+2*YW-1 -: XW];
  assign w_ys = window[XW+2*YW-1 -: YW];
  assign w_xe = window[XW+YW-1 -: XW];
  assign w_ye = window[YW-1:0];

  // Extra carry bit keeps x_end/y_end at the top of the range from wrapping.
  assign nx      = {1'b0, x_q} + (XW+1)'(xst_q);
  assign ny      = {1'b0, y_q} + (YW+1)'(yst_q);
  assign x_fits  = (nx <= {1'b0, xe_q});
  assign col_end = (ny > {1'b0, ye_q});

`ifdef SCAN_SERPENTINE_EN
  assign bx       = {1'b0, x_q} - (XW+1)'(xst_q);
  assign bx_fits  = !bx[XW] && (bx[XW-1:0] >= xs_q);
  assign row_more = dir_q ? bx_fits : x_fits;
  assign row_next = dir_q ? bx[XW-1:0] : nx[XW-1:0];
`else
  assign row_more = x_fits;
  assign row_next = nx[XW-1:0];
`endif

  assign hs    = (state_q == SCAN) && ready;
  assign last  = (state_q == SCAN) && !row_more && col_end;
  assign valid = (state_q == SCAN);
  assign x     = x_q;
  assign y     = y_q;
  assign idx   = idx_q;
  assign done  = done_q;

  always_comb begin
    state_n = state_q;
    x_n     = x_q;
    y_n     = y_q;
    idx_n   = idx_q;
    xs_n    = xs_q;
    xe_n    = xe_q;
    ys_n    = ys_q;
    ye_n    = ye_q;
    xst_n   = xst_q;
    yst_n   = yst_q;
    done_n  = 1'b0;
`ifdef SCAN_SERPENTINE_EN
    dir_n   = dir_q;
    xfar_n  = xfar_q;
`endif

    if (hs) begin
      idx_n = idx_q + (XW+YW)'(1);
      if (row_more) begin
        x_n = row_next;
      end else if (!col_end) begin
        y_n = ny[YW-1:0];
`ifdef SCAN_SERPENTINE_EN
        if (!dir_q) begin
          // Only the first row records x_far; later forward rows end there too.
          if (y_q == ys_q) xfar_n = x_q;
          x_n   = (y_q == ys_q) ? x_q : xfar_q;
          dir_n = 1'b1;
        end else begin
          x_n   = xs_q;
          dir_n = 1'b0;
        end
`else
        x_n = xs_q;
`endif
      end else begin
        state_n = IDLE;
        x_n     = '0;
        y_n     = '0;
        done_n  = 1'b1;
      end
    end

    // START overrides the datapath but a coincident final handshake keeps its done pulse.
    if (START) begin
      xs_n  = w_xs;
      xe_n  = w_xe;
      ys_n  = w_ys;
      ye_n  = w_ye;
      xst_n = (x_step == '0) ? SW'(1) : x_step;
      yst_n = (y_step == '0) ? SW'(1) : y_step;
      idx_n = '0;
`ifdef SCAN_SERPENTINE_EN
      dir_n = 1'b0;
`endif
      if ((w_xs > w_xe) || (w_ys > w_ye)) begin
        state_n = IDLE;
        x_n     = '0;
        y_n     = '0;
        done_n  = 1'b1;
      end else begin
        state_n = SCAN;
        x_n     = w_xs;
        y_n     = w_ys;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
      xst_q   <= '0;
      yst_q   <= '0;
      done_q  <= 1'b0;
`ifdef SCAN_SERPENTINE_EN
      dir_q   <= 1'b0;
      xfar_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      idx_q   <= idx_n;
      xs_q    <= xs_n;
      xe_q    <= xe_n;
      ys_q    <= ys_n;
      ye_q    <= ye_n;
      xst_q   <= xst_n;
      yst_q   <= yst_n;
      done_q  <= done_n;
`ifdef SCAN_SERPENTINE_EN
      dir_q   <= dir_n;
      xfar_q  <= xfar_n;
`endif
    end
  end

endmodule

// File: tb/tb_htpa_window_scanner.sv
// Randomised self-checking bench for htpa_window_scanner against a
// loop-based coordinate list model (serpentine order when SCAN_SERPENTINE_EN).
module tb_htpa_window_scanner;

  logic        clk = 1'b0;
  logic        RST, START, ready;
  logic [25:0] window;
  logic [2:0]  x_step, y_step;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [12:0] idx;
  logic        valid, last, done;

  int n_cmp = 0;
  int n_bad = 0;
  int eq_x[$];
  int eq_y[$];

  htpa_window_scanner #(.XW(7), .YW(6), .SW(3)) dut (
    .clk(clk), .RST(RST), .START(START), .window(window),
    .x_step(x_step), .y_step(y_step), .ready(ready),
    .x(x), .y(y), .idx(idx), .valid(valid), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int xs, input int ys, input int xe, input int ye);
    logic [6:0] a, c;
    logic [5:0] b, d;
    a = 7'(xs); b = 6'(ys); c = 7'(xe); d = 6'(ye);
    window = {a, b, c, d};
  endtask

  // Expected coordinate list straight from the window/step definition.
  task automatic build(input int xs, input int ys, input int xe, input int ye,
                       input int xst, input int yst);
    int sx, sy, r;
    int row[$];
    sx = (xst == 0) ? 1 : xst;
    sy = (yst == 0) ? 1 : yst;
    eq_x.delete();
    eq_y.delete();
    r = 0;
    for (int yy = ys; yy <= ye; yy += sy) begin
      row.delete();
      for (int xx = xs; xx <= xe; xx += sx) row.push_back(xx);
`ifdef SCAN_SERPENTINE_EN
      if (r % 2 == 1) row.reverse();
`endif
      foreach (row[i]) begin
        eq_x.push_back(row[i]);
        eq_y.push_back(yy);
      end
      r++;
    end
  endtask

  task automatic run_scan(input int xs, input int ys, input int xe, input int ye,
                          input int xst, input int yst, input int pct,
                          input int stall_k);
    int n, k, budget, stalls;
    build(xs, ys, xe, ye, xst, yst);
    n = eq_x.size();
    set_win(xs, ys, xe, ye);
    x_step = 3'(xst);
    y_step = 3'(yst);
    START  = 1'b1;
    ready  = 1'b0;
    tick();
    START = 1'b0;
    if (n == 0) begin
      chk("degen_valid", valid, 0);
      chk("degen_done", done, 1);
      tick();
      chk("degen_valid2", valid, 0);
      chk("degen_done2", done, 0);
      return;
    end
    k = 0;
    budget = 3000;
    stalls = 3;
    while (k < n && budget > 0) begin
      chk("valid", valid, 1);
      chk("x", x, eq_x[k]);
      chk("y", y, eq_y[k]);
      chk("idx", idx, k);
      chk("last", last, (k == n - 1) ? 1 : 0);
      chk("done_in_scan", done, 0);
      if (k == stall_k && stalls > 0) begin
        ready = 1'b0;
        stalls--;
      end else begin
        ready = ($urandom_range(0, 99) < pct);
      end
      tick();
      if (ready) k++;
      budget--;
    end
    if (budget == 0) chk("timeout", 0, 1);
    chk("end_valid", valid, 0);
    chk("end_done", done, 1);
    chk("end_x", x, 0);
    chk("end_y", y, 0);
    chk("end_idx", idx, n);
    ready = 1'($urandom_range(0, 1));
    tick();
    chk("post_done", done, 0);
    chk("post_idx", idx, n);
    chk("post_valid", valid, 0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; ready = 1'b0;
    window = '0; x_step = '0; y_step = '0;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_idx", idx, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    RST = 1'b0;
    tick();

    // Directed scans
    run_scan(2, 1, 5, 2, 1, 1, 100, -1);
    run_scan(0, 0, 4, 4, 2, 3, 100, -1);
    run_scan(0, 0, 4, 2, 2, 1, 100, -1);
    run_scan(1, 2, 3, 3, 0, 0, 100, -1);
    run_scan(2, 1, 5, 2, 1, 1, 100, 5);
    run_scan(125, 63, 127, 63, 1, 1, 100, -1);
    run_scan(120, 60, 127, 63, 7, 7, 70, -1);
    run_scan(6, 1, 5, 2, 1, 1, 100, -1);
    run_scan(2, 3, 5, 2, 1, 1, 100, -1);

    // Abort mid-scan by START, then RST mid-scan
    set_win(0, 0, 9, 0); x_step = 3'd1; y_step = 3'd1; START = 1'b1;
    tick();
    START = 1'b0; ready = 1'b1;
    tick(); tick(); tick();
    chk("abort_pre_idx", idx, 3);
    chk("abort_pre_x", x, 3);
    set_win(40, 7, 41, 8); START = 1'b1;
    tick();
    START = 1'b0;
    chk("abort_valid", valid, 1);
    chk("abort_x", x, 40);
    chk("abort_y", y, 7);
    chk("abort_idx", idx, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_x2", x, 41);
    chk("abort_done2", done, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstmid_valid", valid, 0);
    chk("rstmid_x", x, 0);
    chk("rstmid_y", y, 0);
    chk("rstmid_idx", idx, 0);
    chk("rstmid_done", done, 0);
    tick();
    chk("rstmid_done2", done, 0);

    // START coinciding with the final handshake: done and new scan together
    ready = 1'b0;
    set_win(10, 5, 10, 5); START = 1'b1;
    tick();
    chk("coin_valid0", valid, 1);
    chk("coin_last0", last, 1);
    set_win(20, 0, 21, 0); ready = 1'b1;
    tick();
    START = 1'b0;
    chk("coin_valid", valid, 1);
    chk("coin_done", done, 1);
    chk("coin_x", x, 20);
    chk("coin_idx", idx, 0);
    tick();
    chk("coin_x2", x, 21);
    chk("coin_last", last, 1);
    chk("coin_done2", done, 0);
    tick();
    chk("coin_end_done", done, 1);
    chk("coin_end_valid", valid, 0);
    ready = 1'b0;
    tick();

    // Randomised windows
    for (int t = 0; t < 25; t++) begin
      int xs, ys, xe, ye;
      xs = $urandom_range(0, 127);
      ys = $urandom_range(0, 63);
      xe = xs + $urandom_range(0, 8) - 1;
      ye = ys + $urandom_range(0, 4) - 1;
      if (xe > 127) xe = 127;
      if (ye > 63) ye = 63;
      if (xe < 0) xe = 0;
      if (ye < 0) ye = 0;
      run_scan(xs, ys, xe, ye, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(30, 100), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
